// File: rtl/iir_inv_eq_pkg.sv
// Shared widths, coefficient indices, FSM encoding and the adder helper
// for the 3-tap inverse equalizer.
package iir_inv_eq_pkg;

    localparam int DATA_W = 8;
    localparam int FRAC   = 4;
    localparam int PROD_W = 16;
    localparam int SUM_W  = 18;

    // coef_sel encodings; SEL_NONE is accepted on the bus but never writes
    localparam logic [1:0] SEL_G0   = 2'd0;
    localparam logic [1:0] SEL_G1   = 2'd1;
    localparam logic [1:0] SEL_G2   = 2'd2;
    localparam logic [1:0] SEL_NONE = 2'd3;

    typedef enum logic [1:0] {
        CFG   = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Plain-vector state constants, bit-identical to state_e
    localparam logic [1:0] ST_CFG   = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Sign-extend three products to the accumulator width and add them.
    // Three full-scale 16-bit products cannot overflow 18 bits.
    function automatic logic signed [SUM_W-1:0] sum3(
        input logic signed [PROD_W-1:0] a,
        input logic signed [PROD_W-1:0] b,
        input logic signed [PROD_W-1:0] c
    );
        logic signed [SUM_W-1:0] ea;
        logic signed [SUM_W-1:0] eb;
        logic signed [SUM_W-1:0] ec;
        ea = {{(SUM_W-PROD_W){a[PROD_W-1]}}, a};
        eb = {{(SUM_W-PROD_W){b[PROD_W-1]}}, b};
        ec = {{(SUM_W-PROD_W){c[PROD_W-1]}}, c};
        return ea + eb + ec;
    endfunction

endpackage

// File: rtl/iir_inv_eq_sat.sv
// Converts the Q8.8-scaled accumulator back to Q4.4: floor shift by FRAC,
// then clamp to the 8-bit signed range and flag any clamping.
module iir_inv_eq_sat
    import iir_inv_eq_pkg::*;
(
    input  logic [SUM_W-1:0]  sum,
    output logic [DATA_W-1:0] q,
    output logic              sat
);

    localparam int SH_W = SUM_W - FRAC;
    localparam logic signed [SH_W-1:0] SAT_MAX = SH_W'(127);
    localparam logic signed [SH_W-1:0] SAT_MIN = SH_W'(-128);

    // Dropping the low FRAC bits of a two's-complement value is a floor shift
    logic signed [SH_W-1:0] shifted_s;
    assign shifted_s = sum[SUM_W-1:FRAC];

    // Clamp to [-128, 127] and raise the flag when clamping happened
    always_comb begin
        q   = 8'h00;
        sat = 1'b0;
        if (shifted_s > SAT_MAX) begin
            q   = 8'h7F;
            sat = 1'b1;
        end else if (shifted_s < SAT_MIN) begin
            q   = 8'h80;
            sat = 1'b1;
        end else begin
            q   = shifted_s[DATA_W-1:0];
            sat = 1'b0;
        end
    end

endmodule

// File: rtl/iir_inv_eq.sv
// 3-tap inverse equalizer w[n] = g0*y[n] + g1*y[n-1] + g2*y[n-2] in Q4.4.
// Stage 1 registers the products, stage 2 registers the saturated sum.
// Coefficient changes while streaming go through shadow registers and are
// committed only once the pipeline has drained, with the history cleared.
module iir_inv_eq
    import iir_inv_eq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       coef_we,
    input  logic [1:0] coef_sel,
    input  logic [7:0] coef_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_sat
);

    logic [1:0] state_r;

    logic signed [DATA_W-1:0] g0_r;
    logic signed [DATA_W-1:0] g1_r;
    logic signed [DATA_W-1:0] g2_r;
    logic signed [DATA_W-1:0] sh0_r;
    logic signed [DATA_W-1:0] sh1_r;
    logic signed [DATA_W-1:0] sh2_r;
    logic [2:0]               written_r;
    logic [2:0]               pending_r;

    logic signed [DATA_W-1:0] hist1_r;
    logic signed [DATA_W-1:0] hist2_r;
    logic                     s1_valid_r;
    logic signed [PROD_W-1:0] p0_r;
    logic signed [PROD_W-1:0] p1_r;
    logic signed [PROD_W-1:0] p2_r;

    logic signed [DATA_W-1:0] coef_s;
    logic signed [DATA_W-1:0] sample_s;
    logic [2:0]               sel_onehot_s;
    logic                     cwe_s;
    logic                     wr_sh_s;
    logic                     adv_s;
    logic                     in_xfer_s;
    logic                     drain_done_s;
    logic [2:0]               written_nxt_s;
    logic [2:0]               pend_nxt_s;
    logic signed [DATA_W-1:0] sh0_nxt_s;
    logic signed [DATA_W-1:0] sh1_nxt_s;
    logic signed [DATA_W-1:0] sh2_nxt_s;
    logic [SUM_W-1:0]         sum_s;
    logic [DATA_W-1:0]        sat_q_s;
    logic                     sat_flag_s;

    assign coef_s   = coef_data;
    assign sample_s = in_data;

    // Decode coef_sel to a one-hot write mask; index 3 selects nothing
    always_comb begin
        sel_onehot_s = 3'b000;
        case (coef_sel)
            SEL_G0:  sel_onehot_s = 3'b001;
            SEL_G1:  sel_onehot_s = 3'b010;
            SEL_G2:  sel_onehot_s = 3'b100;
            default: sel_onehot_s = 3'b000;
        endcase
    end

    assign cwe_s        = coef_we && (sel_onehot_s != 3'b000);
    assign wr_sh_s      = cwe_s && ((state_r == ST_RUN) || (state_r == ST_DRAIN));
    assign adv_s        = !out_valid || out_ready;
    assign in_ready     = (state_r == ST_RUN) && adv_s;
    assign in_xfer_s    = in_valid && in_ready;
    assign drain_done_s = (state_r == ST_DRAIN) && !s1_valid_r && !out_valid;

    // Next values of written/pending masks and shadows, including this cycle's write
    always_comb begin
        written_nxt_s = written_r | ((cwe_s && (state_r == ST_CFG)) ? sel_onehot_s : 3'b000);
        pend_nxt_s    = pending_r | (wr_sh_s ? sel_onehot_s : 3'b000);
        sh0_nxt_s     = (wr_sh_s && sel_onehot_s[0]) ? coef_s : sh0_r;
        sh1_nxt_s     = (wr_sh_s && sel_onehot_s[1]) ? coef_s : sh1_r;
        sh2_nxt_s     = (wr_sh_s && sel_onehot_s[2]) ? coef_s : sh2_r;
    end

    // Control FSM with active/shadow coefficient banks
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_CFG;
            g0_r      <= 8'sd0;
            g1_r      <= 8'sd0;
            g2_r      <= 8'sd0;
            sh0_r     <= 8'sd0;
            sh1_r     <= 8'sd0;
            sh2_r     <= 8'sd0;
            written_r <= 3'b000;
            pending_r <= 3'b000;
        end else begin
            case (state_r)
                ST_CFG: begin
                    if (cwe_s) begin
                        case (coef_sel)
                            SEL_G0:  g0_r <= coef_s;
                            SEL_G1:  g1_r <= coef_s;
                            SEL_G2:  g2_r <= coef_s;
                            default: g0_r <= g0_r;
                        endcase
                    end
                    written_r <= written_nxt_s;
                    if (written_nxt_s == 3'b111) begin
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (wr_sh_s) begin
                        sh0_r     <= sh0_nxt_s;
                        sh1_r     <= sh1_nxt_s;
                        sh2_r     <= sh2_nxt_s;
                        pending_r <= pend_nxt_s;
                        state_r   <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    sh0_r <= sh0_nxt_s;
                    sh1_r <= sh1_nxt_s;
                    sh2_r <= sh2_nxt_s;
                    if (drain_done_s) begin
                        if (pend_nxt_s[0]) g0_r <= sh0_nxt_s;
                        if (pend_nxt_s[1]) g1_r <= sh1_nxt_s;
                        if (pend_nxt_s[2]) g2_r <= sh2_nxt_s;
                        pending_r <= 3'b000;
                        state_r   <= ST_RUN;
                    end else begin
                        pending_r <= pend_nxt_s;
                    end
                end
                default: begin
                    state_r   <= ST_CFG;
                    pending_r <= 3'b000;
                end
            endcase
        end
    end

    // Stage 1: products and sample history; history restarts from zero after a commit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_r <= 1'b0;
            p0_r       <= 16'sd0;
            p1_r       <= 16'sd0;
            p2_r       <= 16'sd0;
            hist1_r    <= 8'sd0;
            hist2_r    <= 8'sd0;
        end else begin
            if (adv_s) begin
                s1_valid_r <= in_xfer_s;
            end
            if (in_xfer_s) begin
                p0_r <= g0_r * sample_s;
                p1_r <= g1_r * hist1_r;
                p2_r <= g2_r * hist2_r;
            end
            if (drain_done_s) begin
                hist1_r <= 8'sd0;
                hist2_r <= 8'sd0;
            end else if (in_xfer_s) begin
                hist2_r <= hist1_r;
                hist1_r <= sample_s;
            end
        end
    end

    assign sum_s = sum3(p0_r, p1_r, p2_r);

    iir_inv_eq_sat u_sat (
        .sum (sum_s),
        .q   (sat_q_s),
        .sat (sat_flag_s)
    );

    // Stage 2: output register, held while downstream stalls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_sat   <= 1'b0;
        end else if (adv_s) begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                out_data <= sat_q_s;
                out_sat  <= sat_flag_s;
            end
        end
    end

endmodule

// File: tb/tb_iir_inv_eq.sv
// Directed bench for iir_inv_eq: table of 3-sample streams plus
// hand-written backpressure, reconfiguration and reset sequences.
module tb_iir_inv_eq;

    logic       clk;
    logic       rst;
    logic       coef_we;
    logic [1:0] coef_sel;
    logic [7:0] coef_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_sat;

    int total;
    int bad;
    logic [7:0] got_q[$];

    typedef struct {
        logic [7:0]  g0;
        logic [7:0]  g1;
        logic [7:0]  g2;
        logic [23:0] y;   // y0 in bits 7:0
        logic [23:0] w;   // w0 in bits 7:0
        logic [2:0]  s;   // sat flag of sample i in bit i
    } vec_t;

    vec_t vecs[5];

    iir_inv_eq dut (
        .clk       (clk),
        .rst       (rst),
        .coef_we   (coef_we),
        .coef_sel  (coef_sel),
        .coef_data (coef_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    // Collect every output transfer, sampled mid-cycle
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) got_q.push_back(out_data);
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        coef_we  = 1'b0;
        in_valid = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic write_coef(input logic [1:0] sel, input logic [7:0] val);
        coef_we   = 1'b1;
        coef_sel  = sel;
        coef_data = val;
        step();
        coef_we = 1'b0;
    endtask

    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        chk(nm, {7'd0, in_ready}, 8'd1);
    endtask

    task automatic configure(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        write_coef(2'd0, a);
        write_coef(2'd1, b);
        write_coef(2'd2, c);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        do_reset();
        out_ready = 1'b1;
        configure(v.g0, v.g1, v.g2);
        wait_ready($sformatf("v%0d_ready", idx));
        for (int t = 0; t < 6; t++) begin
            if (t >= 2 && t <= 4) begin
                chk($sformatf("v%0d_valid%0d", idx, t), {7'd0, out_valid}, 8'd1);
                chk($sformatf("v%0d_data%0d", idx, t - 2), out_data, v.w[(t-2)*8 +: 8]);
                chk($sformatf("v%0d_sat%0d", idx, t - 2), {7'd0, out_sat}, {7'd0, v.s[t-2]});
            end else begin
                chk($sformatf("v%0d_idle%0d", idx, t), {7'd0, out_valid}, 8'd0);
            end
            if (t < 3) begin
                chk($sformatf("v%0d_inrdy%0d", idx, t), {7'd0, in_ready}, 8'd1);
                in_valid = 1'b1;
                in_data  = v.y[t*8 +: 8];
            end else begin
                in_valid = 1'b0;
            end
            step();
        end
    endtask

    initial begin
        logic [7:0] src[6];
        logic [7:0] held;
        logic       held_ok;
        int sent;
        int cyc;

        total     = 0;
        bad       = 0;
        clk       = 1'b0;
        rst       = 1'b0;
        coef_we   = 1'b0;
        coef_sel  = 2'd0;
        coef_data = 8'h00;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;

        vecs[0] = '{8'h10, 8'h00, 8'h00, {8'h30, 8'h20, 8'h10}, {8'h30, 8'h20, 8'h10}, 3'b000};
        vecs[1] = '{8'h10, 8'hE8, 8'h10, {8'h10, 8'h10, 8'h10}, {8'h08, 8'hF8, 8'h10}, 3'b000};
        vecs[2] = '{8'h7F, 8'h00, 8'h00, {8'h00, 8'h80, 8'h7F}, {8'h00, 8'h80, 8'h7F}, 3'b011};
        vecs[3] = '{8'h08, 8'h00, 8'h00, {8'h03, 8'h01, 8'hFF}, {8'h01, 8'h00, 8'hFF}, 3'b000};
        vecs[4] = '{8'h10, 8'h10, 8'h10, {8'h30, 8'h20, 8'h10}, {8'h60, 8'h30, 8'h10}, 3'b000};

        // reset state
        step();
        step();
        chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_sat", {7'd0, out_sat}, 8'd0);
        chk("rst_in_ready", {7'd0, in_ready}, 8'd0);
        rst = 1'b1;
        step();

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // backpressure: 5 stall cycles mid-stream, identity taps
        do_reset();
        configure(8'h10, 8'h00, 8'h00);
        wait_ready("bp_ready");
        got_q.delete();
        for (int i = 0; i < 6; i++) src[i] = 8'((i + 1) * 17);
        sent    = 0;
        held    = 8'h00;
        held_ok = 1'b0;
        cyc     = 0;
        while ((sent < 6 || got_q.size() < 6) && cyc < 40) begin
            out_ready = !(cyc >= 4 && cyc < 9);
            in_valid  = (sent < 6);
            in_data   = (sent < 6) ? src[sent] : 8'h00;
            #1;
            if (out_valid && !out_ready) begin
                if (held_ok) chk($sformatf("bp_hold%0d", cyc), out_data, held);
                chk($sformatf("bp_inrdy%0d", cyc), {7'd0, in_ready}, 8'd0);
                held    = out_data;
                held_ok = 1'b1;
            end else begin
                held_ok = 1'b0;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        chk("bp_count", 8'(got_q.size()), 8'd6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("bp_order%0d", i), (i < got_q.size()) ? got_q[i] : 8'hXX, src[i]);
        end

        // reconfigure g1 mid-stream
        do_reset();
        out_ready = 1'b1;
        configure(8'h10, 8'h00, 8'h00);
        wait_ready("rc_ready0");
        got_q.delete();
        in_valid = 1'b1;
        in_data  = 8'h10;
        step();
        in_data   = 8'h20;
        coef_we   = 1'b1;
        coef_sel  = 2'd1;
        coef_data = 8'h10;
        chk("rc_inrdy_wr", {7'd0, in_ready}, 8'd1);
        step();
        coef_we  = 1'b0;
        in_valid = 1'b0;
        chk("rc_inrdy_fall", {7'd0, in_ready}, 8'd0);
        wait_ready("rc_ready1");
        in_valid = 1'b1;
        in_data  = 8'h30;
        step();
        chk("rc_inrdy_run", {7'd0, in_ready}, 8'd1);
        in_data = 8'h10;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        chk("rc_count", 8'(got_q.size()), 8'd4);
        chk("rc_w0", (got_q.size() > 0) ? got_q[0] : 8'hXX, 8'h10);
        chk("rc_w1_old_g1", (got_q.size() > 1) ? got_q[1] : 8'hXX, 8'h20);
        chk("rc_w2_zero_hist", (got_q.size() > 2) ? got_q[2] : 8'hXX, 8'h30);
        chk("rc_w3_new_g1", (got_q.size() > 3) ? got_q[3] : 8'hXX, 8'h40);

        // reset while out_valid=1, then partial reconfiguration
        do_reset();
        out_ready = 1'b1;
        configure(8'h10, 8'h00, 8'h00);
        wait_ready("rs_ready0");
        in_valid = 1'b1;
        in_data  = 8'h10;
        step();
        step();
        in_valid = 1'b0;
        chk("rs_pre_valid", {7'd0, out_valid}, 8'd1);
        rst = 1'b0;
        #1;
        chk("rs_async_valid", {7'd0, out_valid}, 8'd0);
        chk("rs_async_inrdy", {7'd0, in_ready}, 8'd0);
        chk("rs_async_data", out_data, 8'h00);
        step();
        rst = 1'b1;
        got_q.delete();
        in_valid = 1'b1;
        in_data  = 8'h55;
        write_coef(2'd0, 8'h10);
        write_coef(2'd1, 8'h00);
        write_coef(2'd3, 8'h10);
        repeat (3) step();
        chk("rs_cfg_hold", {7'd0, in_ready}, 8'd0);
        chk("rs_no_accept", 8'(got_q.size()), 8'd0);
        in_valid = 1'b0;
        write_coef(2'd2, 8'h10);
        wait_ready("rs_ready1");
        in_valid = 1'b1;
        in_data  = 8'h20;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        chk("rs_count", 8'(got_q.size()), 8'd1);
        chk("rs_w0", (got_q.size() > 0) ? got_q[0] : 8'hXX, 8'h20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
